// File: rtl/huffman_frame_ctrl.sv
// Frame sequencer for the Huffman pipeline: clear, load, then wait on count/encode/emit.
// Optional per-stage watchdog is built when HUFF_WDOG_EN is defined.
module huffman_frame_ctrl #(
  parameter int MAX_LEN  = 511,
  parameter int CLR_CYC  = 4
`ifdef HUFF_WDOG_EN
  , parameter int WDOG_CYC = 4095
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_req,
  input  logic [8:0] frame_len,
  input  logic       sample_valid,
  input  logic [3:0] sample_in,
  output logic       sample_ready,
  output logic       hc_rst_n,
  output logic       hc_start,
  output logic [3:0] hc_data_in,
  input  logic       data_count_finish,
  input  logic       encoding_finish,
  input  logic       output_done,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err,
  output logic [7:0] frame_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_LOAD = 3'd2,
    S_CNT  = 3'd3,
    S_ENC  = 3'd4,
    S_EMIT = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_e;

  localparam int              CLR_W    = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYC - 1);

  state_e           state_q, state_d;
  logic [8:0]       len_q, len_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [CLR_W-1:0] clr_q, clr_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             hc_rst_n_q, hc_rst_n_d;
  logic             xfer;
  logic             len_ok;
`ifdef HUFF_WDOG_EN
  logic [11:0]      wdog_q, wdog_d;
`endif

  assign xfer   = (state_q == S_LOAD) && sample_valid;
  assign len_ok = (frame_len != 9'd0) && (int'(frame_len) <= MAX_LEN);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      clr_q       <= '0;
      frame_cnt_q <= '0;
      hc_rst_n_q  <= 1'b0;
`ifdef HUFF_WDOG_EN
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      clr_q       <= clr_d;
      frame_cnt_q <= frame_cnt_d;
      hc_rst_n_q  <= hc_rst_n_d;
`ifdef HUFF_WDOG_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    clr_d       = clr_q;
    frame_cnt_d = frame_cnt_q;
`ifdef HUFF_WDOG_EN
    wdog_d      = wdog_q + 12'd1;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (frame_req) begin
          if (len_ok) begin
            state_d = S_CLR;
            len_d   = frame_len;
            cnt_d   = '0;
            clr_d   = '0;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_CLR: begin
        if (clr_q == CLR_LAST) state_d = S_LOAD;
        else                   clr_d   = clr_q + 1'b1;
      end
      S_LOAD: begin
        if (xfer) begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_q + 9'd1 == len_q) state_d = S_CNT;
        end
      end
      S_CNT:  if (data_count_finish) state_d = S_ENC;
      S_ENC:  if (encoding_finish)   state_d = S_EMIT;
      S_EMIT: if (output_done)       state_d = S_DONE;
      S_DONE: begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef HUFF_WDOG_EN
    // A stalled wait state aborts the frame once the watchdog runs out.
    if ((state_q == S_CNT || state_q == S_ENC || state_q == S_EMIT) &&
        state_d == state_q && wdog_q == 12'(WDOG_CYC - 1))
      state_d = S_ERR;
    if (state_d != state_q) wdog_d = '0;
`endif

    // Pipeline reset is registered so it lines up exactly with CLR/ERR residency.
    hc_rst_n_d = !(state_d == S_CLR || state_d == S_ERR);
  end

  always_comb begin
    sample_ready = (state_q == S_LOAD);
    hc_start     = xfer;
    hc_data_in   = xfer ? sample_in : 4'd0;
    busy         = (state_q != S_IDLE);
    frame_done   = (state_q == S_DONE);
    frame_err    = (state_q == S_ERR);
    frame_cnt    = frame_cnt_q;
    hc_rst_n     = hc_rst_n_q;
    state_o      = state_q;
  end

endmodule

// File: tb/tb_huffman_frame_ctrl.sv
// Directed bench for huffman_frame_ctrl; forwarded symbols are checked against a queue scoreboard.
module tb_huffman_frame_ctrl;

  localparam int CLR_CYC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_req;
  logic [8:0] frame_len;
  logic       sample_valid;
  logic [3:0] sample_in;
  logic       sample_ready;
  logic       hc_rst_n;
  logic       hc_start;
  logic [3:0] hc_data_in;
  logic       data_count_finish;
  logic       encoding_finish;
  logic       output_done;
  logic       busy;
  logic       frame_done;
  logic       frame_err;
  logic [7:0] frame_cnt;
  logic [2:0] state_o;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         start_cnt = 0;
  int         done_cnt  = 0;
  int         err_cnt   = 0;
  logic [3:0] sb_q[$];

  always #5 clk = ~clk;

  huffman_frame_ctrl #(.MAX_LEN(511), .CLR_CYC(CLR_CYC)) dut (
    .clk               (clk),
    .rst               (rst),
    .frame_req         (frame_req),
    .frame_len         (frame_len),
    .sample_valid      (sample_valid),
    .sample_in         (sample_in),
    .sample_ready      (sample_ready),
    .hc_rst_n          (hc_rst_n),
    .hc_start          (hc_start),
    .hc_data_in        (hc_data_in),
    .data_count_finish (data_count_finish),
    .encoding_finish   (encoding_finish),
    .output_done       (output_done),
    .busy              (busy),
    .frame_done        (frame_done),
    .frame_err         (frame_err),
    .frame_cnt         (frame_cnt),
    .state_o           (state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic cyc();
    logic [3:0] exp_sym;
    @(negedge clk);
    if (hc_start === 1'b1) begin
      start_cnt++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_start", 32'd1, 32'd0);
      end else begin
        exp_sym = sb_q.pop_front();
        chk("hc_data_in", 32'(hc_data_in), 32'(exp_sym));
      end
    end
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err  === 1'b1) err_cnt++;
    @(posedge clk);
    #1;
  endtask

  // Issue a legal request and run through CLR into LOAD, checking the clear window.
  task automatic go_load(input logic [8:0] len);
    frame_req = 1'b1;
    frame_len = len;
    cyc();
    frame_req = 1'b0;
    chk("clr_entry_state", 32'(state_o), 32'd1);
    chk("clr_entry_rst_n", 32'(hc_rst_n), 32'd0);
    repeat (CLR_CYC - 1) cyc();
    chk("clr_last_state", 32'(state_o), 32'd1);
    cyc();
    chk("load_state", 32'(state_o), 32'd2);
    chk("load_ready", 32'(sample_ready), 32'd1);
    chk("load_rst_n", 32'(hc_rst_n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int         s0;
    int         d0;
    int         e0;
    logic [9:0] big;
    logic [3:0] syms1 [5];
    logic [3:0] syms2 [4];
    syms1 = '{4'd3, 4'd3, 4'd1, 4'd7, 4'd3};
    syms2 = '{4'd9, 4'd0, 4'd12, 4'd5};

    rst = 1'b1; frame_req = 1'b0; frame_len = '0; sample_valid = 1'b0; sample_in = '0;
    data_count_finish = 1'b0; encoding_finish = 1'b0; output_done = 1'b0;
    repeat (3) cyc();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_hc_rst_n", 32'(hc_rst_n), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(sample_ready), 32'd0);
    rst = 1'b0;
    cyc();
    chk("rst_release", 32'(hc_rst_n), 32'd1);

    // T1: five symbols back to back, staged finish flags.
    s0 = start_cnt; d0 = done_cnt;
    go_load(9'd5);
    foreach (syms1[i]) begin
      sample_valid = 1'b1;
      sample_in    = syms1[i];
      sb_q.push_back(syms1[i]);
      cyc();
    end
    sample_valid = 1'b0;
    chk("t1_cnt_state", 32'(state_o), 32'd3);
    chk("t1_ready_drop", 32'(sample_ready), 32'd0);
    chk("t1_starts", 32'(start_cnt - s0), 32'd5);
    frame_req = 1'b1; frame_len = 9'd3;
    repeat (10) cyc();
    frame_req = 1'b0;
    chk("t1_cnt_wait", 32'(state_o), 32'd3);
    data_count_finish = 1'b1; cyc(); data_count_finish = 1'b0;
    chk("t1_enc", 32'(state_o), 32'd4);
    repeat (20) cyc();
    encoding_finish = 1'b1; cyc(); encoding_finish = 1'b0;
    chk("t1_emit", 32'(state_o), 32'd5);
    repeat (30) cyc();
    output_done = 1'b1; cyc(); output_done = 1'b0;
    chk("t1_done_state", 32'(state_o), 32'd6);
    chk("t1_frame_done", 32'(frame_done), 32'd1);
    cyc();
    chk("t1_idle", 32'(state_o), 32'd0);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("t1_busy_clear", 32'(busy), 32'd0);

    // T2: valid toggling, out-of-range symbol forwarded unchanged.
    s0 = start_cnt;
    go_load(9'd4);
    for (int i = 0; i < 7; i++) begin
      sample_valid = (i % 2 == 0);
      sample_in    = syms2[i / 2];
      if (i % 2 == 0) sb_q.push_back(syms2[i / 2]);
      cyc();
    end
    sample_valid = 1'b0;
    chk("t2_starts", 32'(start_cnt - s0), 32'd4);
    chk("t2_cnt_state", 32'(state_o), 32'd3);
    chk("t2_sb_empty", 32'(sb_q.size()), 32'd0);

    // T4: early/out-of-order flags are ignored; a flag already high advances next cycle.
    encoding_finish = 1'b1; cyc(); encoding_finish = 1'b0;
    cyc();
    chk("t4_enc_early_ignored", 32'(state_o), 32'd3);
    data_count_finish = 1'b1; cyc(); data_count_finish = 1'b0;
    chk("t4_enc_state", 32'(state_o), 32'd4);
    output_done = 1'b1; repeat (3) cyc();
    chk("t4_enc_wait", 32'(state_o), 32'd4);
    encoding_finish = 1'b1; cyc(); encoding_finish = 1'b0;
    chk("t4_emit_state", 32'(state_o), 32'd5);
    cyc(); output_done = 1'b0;
    chk("t4_done_state", 32'(state_o), 32'd6);
    cyc();
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd2);

    // T3: illegal lengths abort without touching the pipeline data path.
    s0 = start_cnt; e0 = err_cnt;
    frame_req = 1'b1; frame_len = 9'd0; cyc(); frame_req = 1'b0;
    chk("t3_err_state", 32'(state_o), 32'd7);
    chk("t3_frame_err", 32'(frame_err), 32'd1);
    chk("t3_err_rst_n", 32'(hc_rst_n), 32'd0);
    cyc();
    chk("t3_back_idle", 32'(state_o), 32'd0);
    chk("t3_err_once", 32'(err_cnt - e0), 32'd1);
    big = 10'd512;
    frame_req = 1'b1; frame_len = big[8:0]; cyc(); frame_req = 1'b0;
    chk("t3b_err_state", 32'(state_o), 32'd7);
    cyc();
    chk("t3b_err_pulses", 32'(err_cnt - e0), 32'd2);
    chk("t3_no_start", 32'(start_cnt - s0), 32'd0);
    chk("t3_cnt_kept", 32'(frame_cnt), 32'd2);

    // T5: reset in the middle of LOAD.
    go_load(9'd6);
    for (int i = 0; i < 2; i++) begin
      sample_valid = 1'b1;
      sample_in    = 4'(i + 2);
      sb_q.push_back(4'(i + 2));
      cyc();
    end
    sample_valid = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t5_state", 32'(state_o), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("t5_rst_n", 32'(hc_rst_n), 32'd0);
    cyc();
    chk("t5_rst_n_release", 32'(hc_rst_n), 32'd1);

    // Boundary: longest legal frame, then shortest, with flags held high.
    s0 = start_cnt;
    go_load(9'd511);
    for (int i = 0; i < 511; i++) begin
      sample_valid = 1'b1;
      sample_in    = 4'(i % 10);
      sb_q.push_back(4'(i % 10));
      cyc();
    end
    sample_valid = 1'b0;
    chk("max_starts", 32'(start_cnt - s0), 32'd511);
    chk("max_cnt_state", 32'(state_o), 32'd3);
    data_count_finish = 1'b1; encoding_finish = 1'b1; output_done = 1'b1;
    repeat (4) cyc();
    data_count_finish = 1'b0; encoding_finish = 1'b0; output_done = 1'b0;
    chk("max_idle", 32'(state_o), 32'd0);
    chk("max_frame_cnt", 32'(frame_cnt), 32'd1);
    go_load(9'd1);
    sample_valid = 1'b1; sample_in = 4'd15; sb_q.push_back(4'd15); cyc();
    sample_valid = 1'b0;
    chk("min_cnt_state", 32'(state_o), 32'd3);
    data_count_finish = 1'b1; encoding_finish = 1'b1; output_done = 1'b1;
    repeat (4) cyc();
    data_count_finish = 1'b0; encoding_finish = 1'b0; output_done = 1'b0;
    chk("min_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
